// File: rtl/seg_pkg.sv
// Shared glyph codes, active-low {g,f,e,d,c,b,a} segment patterns and the decode function.
// Also used by the display-state mapper for its code constants.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [4:0] code_t;
  typedef logic [6:0] seg_t;

  localparam code_t CODE_A     = 5'd10;
  localparam code_t CODE_B     = 5'd11;
  localparam code_t CODE_C     = 5'd12;
  localparam code_t CODE_D     = 5'd13;
  localparam code_t CODE_E     = 5'd14;
  localparam code_t CODE_F     = 5'd15;
  localparam code_t CODE_G     = 5'd16;
  localparam code_t CODE_H     = 5'd17;
  localparam code_t CODE_I     = 5'd18;
  localparam code_t CODE_L     = 5'd19;
  localparam code_t CODE_M     = 5'd20;
  localparam code_t CODE_P     = 5'd21;
  localparam code_t CODE_S     = 5'd22;
  localparam code_t CODE_T     = 5'd23;
  localparam code_t CODE_V     = 5'd24;
  localparam code_t CODE_DASH  = 5'd25;
  localparam code_t CODE_BLANK = 5'd31;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_G     = 7'b1000010;
  localparam seg_t SEG_H     = 7'b0001001;
  localparam seg_t SEG_I     = 7'b1111001;
  localparam seg_t SEG_L     = 7'b1000111;
  localparam seg_t SEG_M     = 7'b1001000;
  localparam seg_t SEG_P     = 7'b0001100;
  localparam seg_t SEG_S     = 7'b0010010;
  localparam seg_t SEG_T     = 7'b0000111;
  localparam seg_t SEG_V     = 7'b1000001;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t seg_decode_f(input code_t code);
    case (code)
      5'd0:       return SEG_0;
      5'd1:       return SEG_1;
      5'd2:       return SEG_2;
      5'd3:       return SEG_3;
      5'd4:       return SEG_4;
      5'd5:       return SEG_5;
      5'd6:       return SEG_6;
      5'd7:       return SEG_7;
      5'd8:       return SEG_8;
      5'd9:       return SEG_9;
      CODE_A:     return SEG_A;
      CODE_B:     return SEG_B;
      CODE_C:     return SEG_C;
      CODE_D:     return SEG_D;
      CODE_E:     return SEG_E;
      CODE_F:     return SEG_F;
      CODE_G:     return SEG_G;
      CODE_H:     return SEG_H;
      CODE_I:     return SEG_I;
      CODE_L:     return SEG_L;
      CODE_M:     return SEG_M;
      CODE_P:     return SEG_P;
      CODE_S:     return SEG_S;
      CODE_T:     return SEG_T;
      CODE_V:     return SEG_V;
      CODE_DASH:  return SEG_DASH;
      default:    return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational 5-bit glyph code to active-low 7-segment pattern lookup.
module seg_decode
  import seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_decode_f(code);
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Six-digit common-anode scan driver with per-frame shadowing of glyph codes.
// Optional digit blinking is built when SEG_BLINK_EN is defined.
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] disp0,
  input  logic [4:0] disp1,
  input  logic [4:0] disp2,
  input  logic [4:0] disp3,
  input  logic [4:0] disp4,
  input  logic [4:0] disp5,
  input  logic [5:0] blink_mask,
  output logic [6:0] seg_n,
  output logic [5:0] an_n,
  output logic       frame_start
);

  localparam int             PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [2:0]     IDX_LAST  = 3'(NUM_DIGITS - 1);

  code_t          disp   [NUM_DIGITS];
  code_t          shadow [NUM_DIGITS];
  logic [PW-1:0]  presc;
  logic [2:0]     idx;
  logic [2:0]     idx_next;
  logic           tick;
  logic           load;
  code_t          dec_code;
  seg_t           dec_seg;
  logic           blank;

  // On a frame-load edge the shadows are being written, so digit 0 must be taken
  // straight from the inputs to show the new frame without a one-slot lag.
  always_comb begin
    disp[0]  = disp0;
    disp[1]  = disp1;
    disp[2]  = disp2;
    disp[3]  = disp3;
    disp[4]  = disp4;
    disp[5]  = disp5;
    tick     = (presc == PRESC_MAX);
    idx_next = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    load     = tick && (idx == IDX_LAST);
    dec_code = load ? disp[idx_next] : shadow[idx_next];
  end

  seg_decode u_decode (
    .code (dec_code),
    .seg  (dec_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc       <= '0;
      idx         <= IDX_LAST;
      seg_n       <= '1;
      an_n        <= '1;
      frame_start <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= CODE_BLANK;
      end
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      frame_start <= load;
      if (tick) begin
        idx   <= idx_next;
        an_n  <= ~(6'b000001 << idx_next);
        seg_n <= blank ? '1 : dec_seg;
      end
      if (load) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          shadow[i] <= disp[i];
        end
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int            FW       = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt;
  logic          phase;
  logic          phase_next;
  logic [5:0]    shadow_blink;
  logic          blink_bit;

  // The phase computed for a load edge already governs the frame that edge starts.
  always_comb begin
    phase_next = phase;
    if (load && (fcnt == FCNT_MAX)) begin
      phase_next = ~phase;
    end
    blink_bit = load ? blink_mask[idx_next] : shadow_blink[idx_next];
    blank     = blink_bit & phase_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt         <= FCNT_MAX;
      phase        <= 1'b1;
      shadow_blink <= '0;
    end else if (load) begin
      fcnt         <= (fcnt == FCNT_MAX) ? '0 : fcnt + 1'b1;
      phase        <= phase_next;
      shadow_blink <= blink_mask;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (^blink_mask) ^ (BLINK_FRAMES == 0);
  assign blank        = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver: stimulus pushes expected digit slots,
// a monitor pops one entry whenever the active anode changes.
module tb_seven_seg_scan_driver;

  localparam int SCAN_DIV = 4;
  localparam int BF       = 2;

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
    logic       fs;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] codes [6];
  logic [5:0] mask  = 6'b000001;
  logic [6:0] seg_n;
  logic [5:0] an_n;
  logic       frame_start;

  int   cyc;
  int   errors = 0;
  int   checks = 0;
  int   fnum   = 0;
  bit   done   = 1'b0;
  exp_t q [$];

  int tbl [9][6] = '{
    '{ 8,  8,  8,  8,  8,  8},
    '{ 1,  8,  8,  8,  8,  8},
    '{14,  8,  8,  8,  8,  8},
    '{25, 26, 31,  1,  8,  8},
    '{ 5, 10, 11, 12, 13, 15},
    '{ 5, 16, 17, 18, 19, 20},
    '{ 5, 21, 22, 23, 24,  9},
    '{ 5,  0,  2,  3,  4,  6},
    '{ 5,  7,  9,  0,  1,  2}
  };

  seven_seg_scan_driver #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .disp0       (codes[0]),
    .disp1       (codes[1]),
    .disp2       (codes[2]),
    .disp3       (codes[3]),
    .disp4       (codes[4]),
    .disp5       (codes[5]),
    .blink_mask  (mask),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic logic [6:0] exp_seg(input logic [4:0] c);
    case (c)
      5'd0:  return 7'h40;
      5'd1:  return 7'h79;
      5'd2:  return 7'h24;
      5'd3:  return 7'h30;
      5'd4:  return 7'h19;
      5'd5:  return 7'h12;
      5'd6:  return 7'h02;
      5'd7:  return 7'h78;
      5'd8:  return 7'h00;
      5'd9:  return 7'h10;
      5'd10: return 7'h08;
      5'd11: return 7'h03;
      5'd12: return 7'h46;
      5'd13: return 7'h21;
      5'd14: return 7'h06;
      5'd15: return 7'h0E;
      5'd16: return 7'h42;
      5'd17: return 7'h09;
      5'd18: return 7'h79;
      5'd19: return 7'h47;
      5'd20: return 7'h48;
      5'd21: return 7'h0C;
      5'd22: return 7'h12;
      5'd23: return 7'h07;
      5'd24: return 7'h41;
      5'd25: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc != n && guard < 1000);
    check("wait_cyc", 32'(cyc), 32'(n));
  endtask

  task automatic push_frame(input int load_cyc, input int ndig);
    exp_t e;
    logic blank;
    fnum++;
    for (int d = 0; d < ndig; d++) begin
      blank = 1'b0;
`ifdef SEG_BLINK_EN
      blank = mask[d] && ((((fnum - 1) / BF) % 2) == 1);
`endif
      e.an  = ~(6'b000001 << d);
      e.seg = blank ? 7'h7F : exp_seg(codes[d]);
      e.fs  = (d == 0);
      e.cyc = load_cyc + SCAN_DIV * d;
      q.push_back(e);
    end
  endtask

  task automatic set_codes(input int k);
    for (int d = 0; d < 6; d++) codes[d] = 5'(tbl[k][d]);
  endtask

  initial begin
    set_codes(0);
    fork
      begin : monitor
        logic [5:0] prev_an = 6'h3F;
        exp_t e;
        while (!done) begin
          @(negedge clk);
          if (an_n !== prev_an) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_slot: got an_n=%b with no expected entry at %0t", an_n, $time);
            end else begin
              e = q.pop_front();
              check("an_n", 32'(an_n), 32'(e.an));
              check("seg_n", 32'(seg_n), 32'(e.seg));
              check("frame_start", 32'(frame_start), 32'(e.fs));
              if (e.cyc >= 0) check("slot_time", 32'(cyc), 32'(e.cyc));
            end
          end else begin
            check("frame_start_idle", 32'(frame_start), 32'd0);
          end
          prev_an = an_n;
        end
      end
      begin : stimulus
        exp_t r;
        int load;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_seg", 32'(seg_n), 32'h7F);
        check("reset_an", 32'(an_n), 32'h3F);
        check("reset_fs", 32'(frame_start), 32'd0);
        rst = 1'b1;

        load = 4;
        for (int k = 0; k < 8; k++) begin
          wait_cyc(load - 1);
          push_frame(load, 6);
          wait_cyc(load + 2);
          set_codes(k + 1);
          load += 6 * SCAN_DIV;
        end

        // Ninth frame is cut short by a reset while digit 3 is being shown.
        wait_cyc(load - 1);
        push_frame(load, 4);
        r.an  = 6'h3F;
        r.seg = 7'h7F;
        r.fs  = 1'b0;
        r.cyc = -1;
        q.push_back(r);
        wait_cyc(load + 3 * SCAN_DIV + 1);
        #1 rst = 1'b0;
        #1;
        check("midreset_seg", 32'(seg_n), 32'h7F);
        check("midreset_an", 32'(an_n), 32'h3F);
        check("midreset_fs", 32'(frame_start), 32'd0);
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        fnum = 0;

        load = 4;
        for (int k = 0; k < 3; k++) begin
          wait_cyc(load - 1);
          push_frame(load, 6);
          load += 6 * SCAN_DIV;
        end

        for (int g = 0; g < 200 && q.size() != 0; g++) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        done = 1'b1;
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
